// File: rtl/wb_write_merge_queue.sv
// wb_write_merge_queue
// Write-back merge stage for the 2-issue pipeline. Takes up to two register
// results per cycle (lane 0 older, lane 1 younger), queues them in program
// order and issues one register write per cycle to the 1-to-16 write-data
// demux in front of the register bank.
//
// Optional feature macro: WB_MERGE_BYPASS_EN
//   defined   : when the queue is empty, the oldest accepted lane is loaded
//               straight into the output registers (1-cycle latency).
//   undefined : every result passes through the queue (2-cycle latency).
//
// Handshake: in_ready_o depends only on registered occupancy. A lane is
// taken at a rising edge when its valid is high, in_ready_o is high, flush_i
// is low and its destination index is non-zero. Valid while in_ready_o is
// low is ignored; upstream holds its inputs until the pair is taken.

module wb_write_merge_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       wb0_valid_i,
    input  logic [SEL_W-1:0]           wb0_rd_i,
    input  logic [DATA_W-1:0]          wb0_data_i,
    input  logic                       wb1_valid_i,
    input  logic [SEL_W-1:0]           wb1_rd_i,
    input  logic [DATA_W-1:0]          wb1_data_i,
    output logic                       in_ready_o,
    output logic                       wr_en_o,
    output logic [SEL_W-1:0]           wr_sel_o,
    output logic [DATA_W-1:0]          wr_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Queue state
    logic [CW-1:0]     count_q;
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [SEL_W-1:0]  rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // Lane acceptance after x0 and collision filtering
    logic acc0_raw;
    logic acc1;
    logic acc0;
    logic queue_empty;
    logic deq;

    // Oldest/second accepted result, in program order
    logic              first_v;
    logic [SEL_W-1:0]  first_rd;
    logic [DATA_W-1:0] first_data;
    logic              second_v;

    // Entries actually written into the queue this edge
    logic              e0_v;
    logic [SEL_W-1:0]  e0_rd;
    logic [DATA_W-1:0] e0_data;
    logic              e1_v;
    logic [SEL_W-1:0]  e1_rd;
    logic [DATA_W-1:0] e1_data;
    logic [CW-1:0]     enq_n;

    // Output register load source
    logic              load;
    logic [SEL_W-1:0]  load_rd;
    logic [DATA_W-1:0] load_data;

    logic [PW-1:0]     tail_p1;

    // Room for a full pair, judged from registered occupancy only
    assign in_ready_o  = (count_q <= CW'(DEPTH - 2));
    assign queue_empty = (count_q == '0);
    assign deq         = !queue_empty && !flush_i;
    assign tail_p1     = tail_q + PW'(1);

    assign count_o = count_q;
    assign busy_o  = (count_q != '0) || wr_en_o;

    // Lane filtering: x0 writes dropped, younger lane wins a same-index pair
    always_comb begin
        acc0_raw = wb0_valid_i && in_ready_o && !flush_i && (wb0_rd_i != '0);
        acc1     = wb1_valid_i && in_ready_o && !flush_i && (wb1_rd_i != '0);
        acc0     = acc0_raw && !(acc1 && (wb0_rd_i == wb1_rd_i));

        first_v    = acc0 || acc1;
        first_rd   = acc0 ? wb0_rd_i   : wb1_rd_i;
        first_data = acc0 ? wb0_data_i : wb1_data_i;
        second_v   = acc0 && acc1;
    end

    // Choose what is enqueued and what is loaded into the output registers
    always_comb begin
        e0_v      = first_v;
        e0_rd     = first_rd;
        e0_data   = first_data;
        e1_v      = second_v;
        e1_rd     = wb1_rd_i;
        e1_data   = wb1_data_i;
        load      = deq;
        load_rd   = rd_mem[head_q];
        load_data = data_mem[head_q];
`ifdef WB_MERGE_BYPASS_EN
        // Empty queue: oldest result skips the queue, the younger one (if
        // any) becomes the only enqueued entry
        if (queue_empty && first_v) begin
            load      = 1'b1;
            load_rd   = first_rd;
            load_data = first_data;
            e0_v      = second_v;
            e0_rd     = wb1_rd_i;
            e0_data   = wb1_data_i;
            e1_v      = 1'b0;
        end
`endif
        enq_n = CW'(e0_v) + CW'(e1_v);
    end

    // Queue storage; contents need no reset since occupancy guards them
    always_ff @(posedge clk_i) begin
        if (e0_v) begin
            rd_mem[tail_q]   <= e0_rd;
            data_mem[tail_q] <= e0_data;
        end
        if (e1_v) begin
            rd_mem[tail_p1]   <= e1_rd;
            data_mem[tail_p1] <= e1_data;
        end
    end

    // Pointers and occupancy; flush overrides enqueue and dequeue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (flush_i) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_q + enq_n - CW'(deq);
            head_q  <= head_q + PW'(deq);
            tail_q  <= tail_q + PW'(enq_n);
        end
    end

    // Write port registers; select/data hold when nothing is issued
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_o   <= 1'b0;
            wr_sel_o  <= '0;
            wr_data_o <= '0;
        end else if (flush_i) begin
            wr_en_o <= 1'b0;
        end else begin
            wr_en_o <= load;
            if (load) begin
                wr_sel_o  <= load_rd;
                wr_data_o <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_merge_queue.sv
// Testbench for wb_write_merge_queue: directed vector table, hand sequences
// for back-pressure, flush and async reset, then random traffic against a
// queue-based reference model.

module tb_wb_write_merge_queue;

    localparam int DEPTH = 4;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        wb0_valid_i;
    logic [3:0]  wb0_rd_i;
    logic [31:0] wb0_data_i;
    logic        wb1_valid_i;
    logic [3:0]  wb1_rd_i;
    logic [31:0] wb1_data_i;
    logic        in_ready_o;
    logic        wr_en_o;
    logic [3:0]  wr_sel_o;
    logic [31:0] wr_data_o;
    logic [2:0]  count_o;
    logic        busy_o;

    wb_write_merge_queue #(.DEPTH(DEPTH), .DATA_W(32), .SEL_W(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .wb0_valid_i(wb0_valid_i),
        .wb0_rd_i   (wb0_rd_i),
        .wb0_data_i (wb0_data_i),
        .wb1_valid_i(wb1_valid_i),
        .wb1_rd_i   (wb1_rd_i),
        .wb1_data_i (wb1_data_i),
        .in_ready_o (in_ready_o),
        .wr_en_o    (wr_en_o),
        .wr_sel_o   (wr_sel_o),
        .wr_data_o  (wr_data_o),
        .count_o    (count_o),
        .busy_o     (busy_o)
    );

    // Clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

`ifdef WB_MERGE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a plain FIFO of pending writes plus the write port
    logic [3:0]  m_rd[$];
    logic [31:0] m_data[$];
    logic        m_en;
    logic [3:0]  m_sel;
    logic [31:0] m_wdata;

    // Scoreboard of expected writes {rd, data}
    logic [35:0] exp_q[$];

    typedef struct {
        logic        v0;
        logic [3:0]  rd0;
        logic [31:0] d0;
        logic        v1;
        logic [3:0]  rd1;
        logic [31:0] d1;
        logic        en;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [2:0]  cnt;
        logic        rdy;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (DEPTH - m_rd.size()) >= 2;
    endfunction

    task automatic model_reset();
        m_rd.delete();
        m_data.delete();
        m_en    = 1'b0;
        m_sel   = '0;
        m_wdata = '0;
    endtask

    // One clock edge of the specified behaviour, from the sampled inputs
    task automatic model_edge();
        logic [3:0]  p_rd[$];
        logic [31:0] p_data[$];
        bit a0, a1, rdy;
        if (flush_i) begin
            m_rd.delete();
            m_data.delete();
            m_en = 1'b0;
            return;
        end
        rdy = m_ready();
        a0  = wb0_valid_i && rdy && (wb0_rd_i != 0);
        a1  = wb1_valid_i && rdy && (wb1_rd_i != 0);
        if (a0 && a1 && wb0_rd_i == wb1_rd_i) a0 = 0;
        if (a0) begin p_rd.push_back(wb0_rd_i); p_data.push_back(wb0_data_i); end
        if (a1) begin p_rd.push_back(wb1_rd_i); p_data.push_back(wb1_data_i); end
        if (m_rd.size() > 0) begin
            m_en    = 1'b1;
            m_sel   = m_rd.pop_front();
            m_wdata = m_data.pop_front();
        end else if (BYPASS && p_rd.size() > 0) begin
            m_en    = 1'b1;
            m_sel   = p_rd.pop_front();
            m_wdata = p_data.pop_front();
        end else begin
            m_en = 1'b0;
        end
        foreach (p_rd[i]) begin
            m_rd.push_back(p_rd[i]);
            m_data.push_back(p_data[i]);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en_o), 32'(m_en));
        chk({tag, "_wr_sel"}, 32'(wr_sel_o), 32'(m_sel));
        chk({tag, "_wr_data"}, wr_data_o, m_wdata);
        chk({tag, "_count"}, 32'(count_o), 32'(m_rd.size()));
        chk({tag, "_ready"}, 32'(in_ready_o), 32'(m_ready()));
        chk({tag, "_busy"}, 32'(busy_o), 32'((m_rd.size() != 0) || m_en));
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        flush_i     = 1'b0;
        wb0_valid_i = 1'b0;
        wb1_valid_i = 1'b0;
    endtask

    task automatic drive_pair(input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                              input logic v1, input logic [3:0] r1, input logic [31:0] d1);
        wb0_valid_i = v0; wb0_rd_i = r0; wb0_data_i = d0;
        wb1_valid_i = v1; wb1_rd_i = r1; wb1_data_i = d1;
    endtask

    task automatic set_vec(input int i, input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                           input logic v1, input logic [3:0] r1, input logic [31:0] d1,
                           input logic en, input logic [3:0] sel, input logic [31:0] data,
                           input logic [2:0] cnt, input logic rdy);
        tbl[i].v0 = v0; tbl[i].rd0 = r0; tbl[i].d0 = d0;
        tbl[i].v1 = v1; tbl[i].rd1 = r1; tbl[i].d1 = d1;
        tbl[i].en = en; tbl[i].sel = sel; tbl[i].data = data;
        tbl[i].cnt = cnt; tbl[i].rdy = rdy;
    endtask

    initial begin
        bit saw_not_ready;
        int p;
        int guard;
        logic [35:0] exp_w;

        // Vector table: pair ordering, collision, x0 discard
`ifdef WB_MERGE_BYPASS_EN
        set_vec(0, 1, 3, 32'h11111111, 1, 5, 32'h22222222, 1, 3, 32'h11111111, 1, 1);
        set_vec(1, 0, 0, 0,            0, 0, 0,            1, 5, 32'h22222222, 0, 1);
        set_vec(2, 0, 0, 0,            0, 0, 0,            0, 5, 32'h22222222, 0, 1);
        set_vec(3, 0, 0, 0,            0, 0, 0,            0, 5, 32'h22222222, 0, 1);
        set_vec(4, 1, 7, 32'hAAAA0000, 1, 7, 32'hBBBB0000, 1, 7, 32'hBBBB0000, 0, 1);
        set_vec(5, 0, 0, 0,            0, 0, 0,            0, 7, 32'hBBBB0000, 0, 1);
        set_vec(6, 1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 7, 32'hBBBB0000, 0, 1);
        set_vec(7, 0, 0, 0,            0, 0, 0,            0, 7, 32'hBBBB0000, 0, 1);
`else
        set_vec(0, 1, 3, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 32'h00000000, 2, 1);
        set_vec(1, 0, 0, 0,            0, 0, 0,            1, 3, 32'h11111111, 1, 1);
        set_vec(2, 0, 0, 0,            0, 0, 0,            1, 5, 32'h22222222, 0, 1);
        set_vec(3, 0, 0, 0,            0, 0, 0,            0, 5, 32'h22222222, 0, 1);
        set_vec(4, 1, 7, 32'hAAAA0000, 1, 7, 32'hBBBB0000, 0, 5, 32'h22222222, 1, 1);
        set_vec(5, 0, 0, 0,            0, 0, 0,            1, 7, 32'hBBBB0000, 0, 1);
        set_vec(6, 1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 7, 32'hBBBB0000, 0, 1);
        set_vec(7, 0, 0, 0,            0, 0, 0,            0, 7, 32'hBBBB0000, 0, 1);
`endif

        // Reset with random inputs
        rst_ni = 1'b0;
        flush_i = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive_pair($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
                       $urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom);
            flush_i = 1'($urandom_range(0, 1));
            @(posedge clk_i);
            #1;
        end
        check_model("reset");
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_model("post_reset");
        end

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            drive_pair(tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1);
            step();
            chk($sformatf("vec%0d_wr_en", i), 32'(wr_en_o), 32'(tbl[i].en));
            chk($sformatf("vec%0d_wr_sel", i), 32'(wr_sel_o), 32'(tbl[i].sel));
            chk($sformatf("vec%0d_wr_data", i), wr_data_o, tbl[i].data);
            chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready_o), 32'(tbl[i].rdy));
        end
        idle_inputs();

        // Back-pressure: three held pairs, six in-order writes through a wrap
        saw_not_ready = 0;
        p = 0;
        guard = 0;
        while ((p < 3 || exp_q.size() != 0) && guard < 40) begin
            bit will_take;
            if (p < 3)
                drive_pair(1, 4'(2 * p + 1), 32'hC0DE0000 + 32'(2 * p),
                           1, 4'(2 * p + 2), 32'hC0DE0000 + 32'(2 * p + 1));
            else
                idle_inputs();
            will_take = (p < 3) && m_ready();
            step();
            if (will_take) begin
                exp_q.push_back({4'(2 * p + 1), 32'hC0DE0000 + 32'(2 * p)});
                exp_q.push_back({4'(2 * p + 2), 32'hC0DE0000 + 32'(2 * p + 1)});
                p++;
            end
            if (!in_ready_o) saw_not_ready = 1;
            check_model("bp");
            if (wr_en_o) begin
                if (exp_q.size() == 0) begin
                    chk("bp_extra_write", 32'(wr_sel_o), 32'hFFFFFFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("bp_order_sel", 32'(wr_sel_o), 32'(exp_w[35:32]));
                    chk("bp_order_data", wr_data_o, exp_w[31:0]);
                end
            end
            guard++;
        end
        chk("bp_all_accepted", 32'(p), 32'd3);
        chk("bp_all_written", 32'(exp_q.size()), 32'd0);
        chk("bp_ready_dropped", 32'(saw_not_ready), 32'd1);
        idle_inputs();

        // Flush with three queued entries and a same-edge pair
        guard = 0;
        while (m_rd.size() < 3 && guard < 10) begin
            drive_pair(1, 4'($urandom_range(1, 7)), $urandom, 1, 4'($urandom_range(8, 15)), $urandom);
            step();
            check_model("fill");
            guard++;
        end
        chk("flush_prefill_count", 32'(count_o), 32'd3);
        flush_i = 1'b1;
        drive_pair(1, 4'd9, 32'hDEAD0001, 1, 4'd10, 32'hDEAD0002);
        step();
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_wr_en", 32'(wr_en_o), 32'd0);
        chk("flush_busy", 32'(busy_o), 32'd0);
        check_model("flush");
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_flush_no_write", 32'(wr_en_o), 32'd0);
            check_model("post_flush");
        end

        // Async reset mid-stream, asserted between edges while writing
        guard = 0;
        drive_pair(1, 4'd4, 32'h12345678, 1, 4'd6, 32'h9ABCDEF0);
        step();
        check_model("pre_arst");
        drive_pair(1, 4'd2, 32'h0BADF00D, 1, 4'd8, 32'hFEEDBEEF);
        while (!m_en && guard < 5) begin
            step();
            check_model("pre_arst");
            guard++;
        end
        idle_inputs();
        chk("arst_was_writing", 32'(wr_en_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("arst_wr_en", 32'(wr_en_o), 32'd0);
        chk("arst_wr_sel", 32'(wr_sel_o), 32'd0);
        chk("arst_wr_data", wr_data_o, 32'd0);
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_model("post_arst");
        end

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r0;
            r0 = 4'($urandom_range(0, 15));
            flush_i = ($urandom_range(0, 24) == 0);
            drive_pair($urandom_range(0, 1), r0, $urandom,
                       $urandom_range(0, 1),
                       ($urandom_range(0, 3) == 0) ? r0 : 4'($urandom_range(0, 15)),
                       $urandom);
            step();
            check_model("rand");
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            step();
            check_model("drain");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_write_merge_queue.md
Name: wb_write_merge_queue

Overview:
- Write-back merge stage of the 2-issue pipeline.
- Accepts up to two register write-back results per cycle (lane 0 older, lane 1 younger) and queues them in program order.
- Issues one register write per cycle as {wr_en_o, wr_sel_o, wr_data_o}. wr_sel_o drives the 4-bit select and wr_data_o the 32-bit data of the 1-to-16 write-data demultiplexer in front of the register bank.
- Back-pressures the execute stage when the queue cannot take a full pair.

Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- DATA_W, 32: write-back data width.
- SEL_W, 4: destination register index width (16 registers).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous queue clear (pipeline squash).
- wb0_valid_i  in  1  lane 0 result valid.
- wb0_rd_i  in  SEL_W  lane 0 destination index.
- wb0_data_i  in  DATA_W  lane 0 result.
- wb1_valid_i  in  1  lane 1 result valid.
- wb1_rd_i  in  SEL_W  lane 1 destination index.
- wb1_data_i  in  DATA_W  lane 1 result.
- in_ready_o  out  1  queue can accept two entries this cycle.
- wr_en_o  out  1  register write strobe.
- wr_sel_o  out  SEL_W  write index to demux select.
- wr_data_o  out  DATA_W  write data to demux D.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- busy_o  out  1  count_o!=0 or wr_en_o.

Behaviour:
- Reset: while rst_ni=0, asynchronously clear count, head and tail pointers, wr_en_o, wr_sel_o, wr_data_o and busy_o. in_ready_o=1.
- in_ready_o = (DEPTH - count) >= 2, taken from registered count only. It does not look ahead to a same-cycle pop.
- Accept condition: a lane is accepted at a rising edge when its valid=1, in_ready_o=1, flush_i=0 and rd!=0.
  - Writes to index 0 are discarded: x0 is hardwired.
  - Valid asserted while in_ready_o=0 is not accepted and causes no state change. Upstream holds its inputs.
- Same-cycle collision: both lanes accepted with wb0_rd_i==wb1_rd_i. Lane 0 is dropped and only lane 1 is enqueued.
- Order: lane 0 is written at tail and lane 1 at tail+1. If only lane 1 is accepted, it goes at tail. The tail advances by the number enqueued (0/1/2) and wraps modulo DEPTH.
- Dequeue: every cycle with count>0 (after reset, no flush), the head entry is loaded into the output registers at the edge.
  - wr_en_o=1 for exactly one cycle per entry.
  - Head advances by 1 and wraps modulo DEPTH.
  - count_next = count + enq - deq. Enqueue and dequeue in the same edge are both legal.
- When nothing is dequeued: wr_en_o=0; wr_sel_o and wr_data_o hold their last values.
- Latency without bypass: a result accepted at edge E appears on the outputs after edge E+1, i.e. 2 cycles from valid to write.
- Full: at count==DEPTH-1 or DEPTH, in_ready_o=0. count never exceeds DEPTH.
- Flush: flush_i=1 at an edge clears count and pointers and forces wr_en_o=0. Same-edge inputs are ignored. Flush has priority over enqueue and dequeue.
- Reset mid-operation: all queued entries are lost and outputs go to their reset values immediately.

Optional Feature:
- Macro: WB_MERGE_BYPASS_EN.
- Defined: when count==0 at an edge, the oldest accepted lane (after collision and x0 filtering) goes straight into the output registers at that edge, giving 1-cycle latency. The other accepted lane, if any, is enqueued. Ordering is preserved.
- Undefined: every result passes through the queue, giving a fixed 2-cycle latency.

Test Plan:
- Reset: hold rst_ni=0 with random inputs. Expect wr_en_o=0, wr_sel_o=0, wr_data_o=0, count_o=0, in_ready_o=1. Release and check no spurious write.
- Pair ordering: one cycle with wb0 (rd=3, 0x11111111) and wb1 (rd=5, 0x22222222). Expect writes of (3,0x11111111) then (5,0x22222222) on consecutive cycles, the first 2 cycles after valid (1 cycle with WB_MERGE_BYPASS_EN). count_o peaks at 2.
- Collision and x0: wb0 (rd=7, 0xAAAA0000) with wb1 (rd=7, 0xBBBB0000). Expect a single write of (7,0xBBBB0000). Then wb0 (rd=0, 0xFFFFFFFF) alone: no write, count_o stays 0.
- Back-pressure: with DEPTH=4, present pairs on 3 consecutive cycles. in_ready_o drops to 0 once count reaches 3. The third pair is accepted only after in_ready_o returns to 1. All 6 writes come out in order with no loss or duplication; the wrap of the pointers is checked.
- Flush: with 3 queued entries, assert flush_i together with a valid pair. Next cycle expect count_o=0, wr_en_o=0, busy_o=0, and no write from the flushed or same-cycle entries.
- Async reset mid-stream: drop rst_ni between clock edges while wr_en_o=1. Outputs clear immediately, without waiting for a clock edge. After release the queue is empty.
